// File: rtl/fixed_point_round_saturate_stage_pkg.sv
// Shared definitions for the fixed-point round/saturate stage.
// The adder output Q-format, the clamp-limit helpers and the rounding-mode encoding.
package fixed_point_round_saturate_stage_pkg;

    // Q-format of the upstream signed pipelined adder output (Q5.4)
    localparam int unsigned ADD_OUT_W    = 9;
    localparam int unsigned ADD_OUT_FRAC = 4;

    // Rounding modes; only half-up is used today, truncation is kept for future modes
    typedef enum logic [1:0] {
        RND_HALF_UP = 2'd0,
        RND_TRUNC   = 2'd1
    } round_mode_e;

    // Largest value representable in a signed w-bit word
    function automatic int sat_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed w-bit word
    function automatic int sat_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/fxp_saturate.sv
// Combinational signed clamp from IN_W bits to OUT_W bits with a clip flag.
module fxp_saturate
    import fixed_point_round_saturate_stage_pkg::*;
#(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 8
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    if (IN_W > OUT_W) begin : g_clamp
        localparam logic signed [IN_W-1:0] MAXV = IN_W'(sat_max(OUT_W));
        localparam logic signed [IN_W-1:0] MINV = IN_W'(sat_min(OUT_W));

        // Clamp to the output range and flag any sample that was clipped
        always_comb begin
            data_o = data_i[OUT_W-1:0];
            sat_o  = 1'b0;
            if ($signed(data_i) > MAXV) begin
                data_o = MAXV[OUT_W-1:0];
                sat_o  = 1'b1;
            end else if ($signed(data_i) < MINV) begin
                data_o = MINV[OUT_W-1:0];
                sat_o  = 1'b1;
            end
        end
    end else begin : g_extend
        // Output is at least as wide as the input: sign-extend, never clips
        always_comb begin
            data_o = OUT_W'($signed(data_i));
            sat_o  = 1'b0;
        end
    end

endmodule

// File: rtl/fixed_point_round_saturate_stage.sv
// Two-stage valid/ready pipeline: round the adder's Q-format sum to OUT_FRAC bits,
// then saturate to OUT_W bits, tagging clipped samples and counting delivered clips.
module fixed_point_round_saturate_stage
    import fixed_point_round_saturate_stage_pkg::*;
#(
    parameter int unsigned IN_W     = ADD_OUT_W,
    parameter int unsigned IN_FRAC  = ADD_OUT_FRAC,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned OUT_FRAC = 3,
    parameter int unsigned CNT_W    = 16,
    parameter round_mode_e RMODE    = RND_HALF_UP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [CNT_W-1:0] sat_count
);

    localparam int unsigned SHIFT = IN_FRAC - OUT_FRAC;
    localparam int unsigned RW    = IN_W + 1 - SHIFT;
    // Half an output LSB, added before the arithmetic shift for round-half-up
    localparam logic [IN_W:0] HALF =
        (SHIFT > 0 && RMODE == RND_HALF_UP) ? ((IN_W + 1)'(1) << (SHIFT - 1)) : '0;

    logic             s1_valid_q, s1_valid_d;
    logic [RW-1:0]    s1_data_q,  s1_data_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_sat_q,   out_sat_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    logic             en1, en2;
    logic signed [IN_W:0] ext, biased;
    logic [OUT_W-1:0] sat_data;
    logic             sat_flag;

    // One extra headroom bit so adding HALF to the most positive input cannot wrap
    always_comb begin
        ext    = {in_data[IN_W-1], in_data};
        biased = ext + HALF;
    end

    // Handshake enables: a stage may load when it is empty or its contents move on
    always_comb begin
        en2 = !out_valid_q || out_ready;
        en1 = !s1_valid_q || en2;
    end

    fxp_saturate #(
        .IN_W (RW),
        .OUT_W(OUT_W)
    ) u_sat (
        .data_i(s1_data_q),
        .data_o(sat_data),
        .sat_o (sat_flag)
    );

    // Next-state for both pipeline stages; data registers load only on an accepted sample
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (en1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = RW'(biased >>> SHIFT);
            end
        end
        if (en2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sat_data;
                out_sat_d  = sat_flag;
            end
        end
    end

    // Clip counter: clear wins over increment, and it sticks at all-ones instead of wrapping
    always_comb begin
        sat_count_d = sat_count_q;
        if (clr_count) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = en1;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fixed_point_round_saturate_stage.sv
// Self-checking bench for fixed_point_round_saturate_stage (Q5.4 -> Q5.3).
// A reduced counter width makes the sticky all-ones behaviour reachable quickly.
module tb_fixed_point_round_saturate_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SHIFT   = 1;
    localparam int OMAX    = 127;
    localparam int OMIN    = -128;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_sat;
    logic             clr_count;
    logic [CNT_W-1:0] sat_count;

    fixed_point_round_saturate_stage #(
        .IN_W    (9),
        .IN_FRAC (4),
        .OUT_W   (8),
        .OUT_FRAC(3),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .clr_count(clr_count),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit s;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   got_q[$];
    int   cnt_m = 0;
    bit   held_v = 0;
    int   held_d;
    bit   held_s;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Real value x/16 rounded half toward +inf to a multiple of 1/8, then clamped to 8 bits
    function automatic exp_t model(input logic [8:0] raw);
        exp_t e;
        int   x;
        int   r;
        x = $signed(raw);
        r = floor_div(x + (1 << (SHIFT - 1)), 1 << SHIFT);
        e.s = (r > OMAX) || (r < OMIN);
        e.d = (r > OMAX) ? OMAX : (r < OMIN) ? OMIN : r;
        return e;
    endfunction

    // Scoreboard: every cycle compare delivered samples, the counter and stall stability
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_m  = 0;
            held_v = 0;
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_sat_count", int'(sat_count), 0);
        end else begin
            exp_t e;
            bit   hs;
            check("sat_count", int'(sat_count), cnt_m);
            if (held_v) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", $signed(out_data), held_d);
                check("stall_sat", int'(out_sat), int'(held_s));
            end
            held_v = out_valid && !out_ready;
            held_d = $signed(out_data);
            held_s = out_sat;
            hs = out_valid && out_ready;
            e.d = 0;
            e.s = 0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", $signed(out_data), e.d);
                    check("out_sat", int'(out_sat), int'(e.s));
                end
                got_q.push_back($signed(out_data));
            end
            if (clr_count) cnt_m = 0;
            else if (hs && e.s && cnt_m < CNT_MAX) cnt_m++;
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
            check("occupancy_le_2", int'(exp_q.size() <= 2), 1);
        end
    end

    // One sample through an empty pipeline with out_ready high: visible exactly 2 edges later
    task automatic single(input logic [8:0] x, input int ed, input int es);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat1_not_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("lat2_valid", int'(out_valid), 1);
        check("lit_data", $signed(out_data), ed);
        check("lit_sat", int'(out_sat), es);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[6];
        int expv[6];
        int k;
        int waited;
        exp_t e;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_count = 1'b0;

        // Hand-computed points pinning the model
        e = model(9'd6);    check("model_6", e.d, 3);
        e = model(9'd5);    check("model_5", e.d, 3);
        e = model(9'h1FB);  check("model_m5", e.d, -2);
        e = model(9'h0FF);  check("model_255", e.d, 127);  check("model_255_sat", int'(e.s), 1);
        e = model(9'h100);  check("model_m256", e.d, -128); check("model_m256_sat", int'(e.s), 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_sat", int'(out_sat), 0);
        check("reset_sat_count", int'(sat_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", int'(in_ready), 1);

        // Rounding and the range boundaries
        single(9'd6, 3, 0);
        single(9'd5, 3, 0);
        single(9'h1FB, -2, 0);
        single(9'h0FF, 127, 1);
        check("cnt_after_clip", int'(sat_count), 1);
        single(9'h100, -128, 0);
        check("cnt_after_neg_edge", int'(sat_count), 1);

        // Backpressure: 1..6 with out_ready low for 4 cycles
        got_q.delete();
        foreach (vals[i]) vals[i] = i + 1;
        expv = '{1, 1, 2, 2, 3, 3};
        k = 0;
        for (int cyc = 0; cyc < 30 && k < 6; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = 1'b1;
            in_data   = 9'(vals[k]);
            @(negedge clk);
            if (cyc == 3) begin
                check("bp_accepted", k, 2);
                check("bp_in_ready", int'(in_ready), 0);
            end
            if (in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_accepted", k, 6);
        waited = 0;
        while (got_q.size() < 6 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) check("bp_order", got_q[i], expv[i]);

        // Counter sticks at all-ones
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_data  = 9'h0FF;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_hold_ones", int'(sat_count), CNT_MAX);

        // Clear coinciding with a clipped handshake
        in_valid = 1'b1;
        in_data  = 9'h0FF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_pre_valid", int'(out_valid), 1);
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        check("clr_priority", int'(sat_count), 0);
        check("clr_delivered", int'(out_valid), 0);

        // Reset while both stages are full and stalled
        single(9'h0FF, 127, 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 9'd6;
        @(posedge clk); #1;
        in_data = 9'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stall_full_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_sat_count", int'(sat_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("postrst_in_ready", int'(in_ready), 1);
        single(9'd5, 3, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom % 8;
            in_valid  = ($urandom % 4) != 0;
            in_data   = (r == 0) ? 9'h0FF : (r == 1) ? 9'h100 : 9'($urandom);
            out_ready = ($urandom % 3) != 0;
            clr_count = ($urandom % 50) == 0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
